load_store_unit: RTL and testbench

Load/store unit between the execute stage and the synchronous data-memory bus. It turns one load or store request into a bus transaction with byte enables. It aligns and sign- or zero-extends returned read data into the 32-bit value that feeds the memory-data input of the write-back `MemtoReg` select. It stalls the pipeline until the access completes, and flags misaligned accesses and, optionally, bus timeouts.

---
 rtl/lsu_pkg.sv | 43 ++++
 rtl/lsu_load_align.sv | 27 ++
 rtl/load_store_unit.sv | 150 +++++++++++++++
 tb/tb_load_store_unit.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// FSM encoding, access-size codes and store lane/byte-enable helpers.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    // Size code 3 is illegal and behaves exactly like a word everywhere.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return a[0];
            default: return (a != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] a);
        case (size)
            SZ_B:    return 4'b0001 << a;
            SZ_H:    return 4'b0011 << a;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate the right-aligned store data into every lane so the
    // byte enables alone pick the destination bytes.
    function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] d);
        case (size)
            SZ_B:    return {4{d[7:0]}};
            SZ_H:    return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: picks the addressed byte/half lane out of the
// returned little-endian word and sign- or zero-extends it to 32 bits.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane select followed by extension; purely combinational.
    always_comb begin
        w_byte = i_rdata[{i_addr, 3'b000} +: 8];
        w_half = i_rdata[{i_addr[1], 4'b0000} +: 16];
        case (i_size)
            SZ_B:    o_data = {{24{w_byte[7]  & ~i_unsigned}}, w_byte};
            SZ_H:    o_data = {{16{w_half[15] & ~i_unsigned}}, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one execute-stage memory op -> one data-bus transaction.
// Stalls the pipeline while the bus is busy, aligns/extends load data,
// flags misaligned ops. Optional bus timeout enabled by LSU_TIMEOUT_EN.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYC = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    input  logic        op_we,
    input  logic [1:0]  op_size,
    input  logic        op_unsigned,
    input  logic [31:0] op_addr,
    input  logic [31:0] op_wdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_done,
    output logic        misalign_exc,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    state_t      r_state, w_next;
    logic        r_mem_req, r_mem_we, r_load_done, r_misal, r_bus_err;
    logic [31:0] r_mem_addr, r_mem_wdata, r_load_data;
    logic [3:0]  r_mem_be;
    // Access attributes kept for the aligner while the load is in flight.
    logic [1:0]  r_lo, r_size;
    logic        r_uns;

    logic        w_accept, w_misal, w_timeout, w_complete, w_err;
    logic [31:0] w_ext;

    assign w_accept = (r_state == IDLE) && op_valid;
    assign w_misal  = is_misaligned(op_size, op_addr[1:0]);

    lsu_load_align u_align (
        .i_rdata    (mem_rdata),
        .i_addr     (r_lo),
        .i_size     (r_size),
        .i_unsigned (r_uns),
        .o_data     (w_ext)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
    logic [CW-1:0] r_cnt;

    // Cycles spent in REQ+WAIT for the current op; cleared while idle so
    // it starts from zero on entry to REQ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (r_state == IDLE)
            r_cnt <= '0;
        else if (r_state == REQ || r_state == WAIT)
            r_cnt <= r_cnt + CW'(1);
    end

    assign w_timeout = (r_state == REQ || r_state == WAIT) &&
                       (r_cnt == CW'(TIMEOUT_CYC - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // A real completion in the last allowed cycle wins over the timeout.
    assign w_complete = (r_state == REQ && mem_gnt) || (r_state == WAIT && mem_rvalid);
    assign w_err      = w_timeout && !w_complete;

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (op_valid) w_next = w_misal ? DONE : REQ;
            REQ:  if (mem_gnt)  w_next = r_mem_we ? DONE : WAIT;
                  else if (w_timeout) w_next = DONE;
            WAIT: if (mem_rvalid || w_timeout) w_next = DONE;
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State plus registered outputs derived from the next state, so every
    // output except stall comes straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_mem_req   <= 1'b0;
            r_load_done <= 1'b0;
            r_misal     <= 1'b0;
            r_bus_err   <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_mem_req   <= (w_next == REQ);
            r_load_done <= (w_next == DONE);
            r_misal     <= w_accept && w_misal;
            r_bus_err   <= w_err;
        end
    end

    // Bus request fields captured once at accept and held through REQ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= '0;
            r_mem_wdata <= '0;
            r_lo        <= '0;
            r_size      <= '0;
            r_uns       <= 1'b0;
        end else if (w_accept && !w_misal) begin
            r_mem_we    <= op_we;
            r_mem_addr  <= {op_addr[31:2], 2'b00};
            r_mem_be    <= op_we ? store_be(op_size, op_addr[1:0]) : 4'b1111;
            r_mem_wdata <= store_wdata(op_size, op_wdata);
            r_lo        <= op_addr[1:0];
            r_size      <= op_size;
            r_uns       <= op_unsigned;
        end
    end

    // Load result only changes on a successful read return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_load_data <= '0;
        else if (r_state == WAIT && mem_rvalid)
            r_load_data <= w_ext;
    end

    assign stall        = (r_state == REQ) || (r_state == WAIT) || w_accept;
    assign load_data    = r_load_data;
    assign load_done    = r_load_done;
    assign misalign_exc = r_misal;
    assign bus_err      = r_bus_err;
    assign mem_req      = r_mem_req;
    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_be       = r_mem_be;
    assign mem_wdata    = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: each op pushes its expected
// completion; a monitor pops and compares when load_done pulses.
module tb_load_store_unit;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid = 1'b0, op_we = 1'b0, op_unsigned = 1'b0;
    logic [1:0]  op_size = 2'd0;
    logic [31:0] op_addr = '0, op_wdata = '0;
    logic        stall, load_done, misalign_exc, bus_err, mem_req, mem_we;
    logic [31:0] load_data, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    load_store_unit #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .op_valid(op_valid), .op_we(op_we), .op_size(op_size),
        .op_unsigned(op_unsigned), .op_addr(op_addr), .op_wdata(op_wdata),
        .stall(stall), .load_data(load_data), .load_done(load_done),
        .misalign_exc(misalign_exc), .bus_err(bus_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic        mis;
        logic        err;
        int          lat;
        int          start;
    } exp_t;

    exp_t        q[$];
    exp_t        m_e;
    int          n_chk = 0, n_err = 0;
    logic [31:0] model_ld = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Completion monitor.
    always @(posedge clk) begin
        #1;
        if (rst_n && load_done) begin
            if (q.size() == 0) begin
                chk("spurious_done", 32'(load_done), 32'd0);
            end else begin
                m_e = q.pop_front();
                chk({m_e.tag, "_data"},  load_data, m_e.data);
                chk({m_e.tag, "_mis"},   32'(misalign_exc), 32'(m_e.mis));
                chk({m_e.tag, "_err"},   32'(bus_err), 32'(m_e.err));
                chk({m_e.tag, "_lat"},   32'(cyc - m_e.start), 32'(m_e.lat));
                chk({m_e.tag, "_req0"},  32'(mem_req), 32'd0);
                chk({m_e.tag, "_stall"}, 32'(stall), 32'd0);
            end
        end
    end

    // One op plus a bus responder. gdly/rdly = cycles of REQ/WAIT before
    // gnt/rvalid is given (-1 = never).
    task automatic run_op(input string tag, input logic we, input logic [1:0] sz,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rd, input int gdly, input int rdly,
                          input logic exp_req, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd, input logic upd,
                          input logic [31:0] new_ld, input logic mis, input logic err,
                          input int lat);
        exp_t e;
        int   n, rq, wt;
        bit   done, granted, seen_req;
        @(posedge clk); #1;
        op_we = we; op_size = sz; op_unsigned = uns; op_addr = addr; op_wdata = wd;
        op_valid = 1'b1;
        if (upd) model_ld = new_ld;
        e = '{tag, model_ld, mis, err, lat, cyc};
        q.push_back(e);
        #1 chk({tag, "_stall1"}, 32'(stall), 32'd1);
        done = 0; granted = 0; seen_req = 0; rq = 0; wt = 0; n = 0;
        while (!done && n < 200) begin
            @(posedge clk); #1;
            n++;
            mem_gnt = 1'b0; mem_rvalid = 1'b0;
            if (load_done) begin
                done = 1;
            end else if (mem_req) begin
                if (!seen_req) begin
                    seen_req = 1;
                    chk({tag, "_addr"}, mem_addr, addr & 32'hFFFF_FFFC);
                    chk({tag, "_be"},   32'(mem_be), 32'(exp_be));
                    chk({tag, "_we"},   32'(mem_we), 32'(we));
                    if (we) chk({tag, "_wdata"}, mem_wdata, exp_wd);
                end
                if (rq == gdly) begin mem_gnt = 1'b1; granted = 1; end
                rq++;
            end else if (granted && !we) begin
                if (wt == rdly) begin mem_rvalid = 1'b1; mem_rdata = rd; end
                wt++;
            end
        end
        op_valid = 1'b0;
        if (!done) chk({tag, "_done"}, 32'(load_done), 32'd1);
        chk({tag, "_req"}, 32'(seen_req), 32'(exp_req));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        chk({tag, "_ld"},    load_data, 32'd0);
        chk({tag, "_flags"}, {29'd0, load_done, misalign_exc, bus_err}, 32'd0);
        chk({tag, "_req"},   {31'd0, mem_req}, 32'd0);
        chk({tag, "_we"},    {31'd0, mem_we}, 32'd0);
        chk({tag, "_addr"},  mem_addr, 32'd0);
        chk({tag, "_be"},    {28'd0, mem_be}, 32'd0);
        chk({tag, "_wdata"}, mem_wdata, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_err);
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 chk_all_zero("rst");
        rst_n = 1'b1;

        //     tag       we sz    u  addr          wdata         rdata         g  r  req be       exp_wd        upd new_ld        mis err lat
        run_op("lb",     0, 2'd0, 0, 32'h1003,     32'h0,        32'h80FF1234, 0, 0, 1, 4'b1111, 32'h0,        1, 32'hFFFFFF80, 0, 0, 3);
        run_op("lhu",    0, 2'd1, 1, 32'h2002,     32'h0,        32'hBEEF0001, 0, 0, 1, 4'b1111, 32'h0,        1, 32'h0000BEEF, 0, 0, 3);
        run_op("sb",     1, 2'd0, 0, 32'h11,       32'hAB,       32'h0,        2, 0, 1, 4'b0010, 32'hABABABAB, 0, 32'h0,        0, 0, 4);
        run_op("lw_mis", 0, 2'd2, 0, 32'h6,        32'h0,        32'h0,        0, 0, 0, 4'b1111, 32'h0,        0, 32'h0,        1, 0, 1);
        run_op("lh",     0, 2'd1, 0, 32'h0,        32'h0,        32'h00008001, 0, 1, 1, 4'b1111, 32'h0,        1, 32'hFFFF8001, 0, 0, 4);
        run_op("sh",     1, 2'd1, 0, 32'h2,        32'h12345678, 32'h0,        0, 0, 1, 4'b1100, 32'h56785678, 0, 32'h0,        0, 0, 2);
        run_op("sw",     1, 2'd2, 0, 32'h8,        32'hDEADBEEF, 32'h0,        1, 0, 1, 4'b1111, 32'hDEADBEEF, 0, 32'h0,        0, 0, 3);
        run_op("lbu",    0, 2'd0, 1, 32'h1,        32'h0,        32'h00008000, 1, 0, 1, 4'b1111, 32'h0,        1, 32'h00000080, 0, 0, 4);
        run_op("lh_mis", 0, 2'd1, 0, 32'h3,        32'h0,        32'h0,        0, 0, 0, 4'b1111, 32'h0,        0, 32'h0,        1, 0, 1);
        run_op("sh_mis", 1, 2'd1, 0, 32'h5,        32'h1234,     32'h0,        0, 0, 0, 4'b1111, 32'h0,        0, 32'h0,        1, 0, 1);
        run_op("lw3",    0, 2'd3, 0, 32'h10,       32'h0,        32'hCAFEF00D, 0, 0, 1, 4'b1111, 32'h0,        1, 32'hCAFEF00D, 0, 0, 3);
        run_op("sb3",    1, 2'd0, 0, 32'h3,        32'h5A,       32'h0,        0, 0, 1, 4'b1000, 32'h5A5A5A5A, 0, 32'h0,        0, 0, 2);
        run_op("lb_pos", 0, 2'd0, 0, 32'h2,        32'h0,        32'h007F0000, 0, 0, 1, 4'b1111, 32'h0,        1, 32'h0000007F, 0, 0, 3);
        run_op("lh_hi",  0, 2'd1, 0, 32'hFFFF0002, 32'h0,        32'h80001234, 0, 0, 1, 4'b1111, 32'h0,        1, 32'hFFFF8000, 0, 0, 3);
`ifdef LSU_TIMEOUT_EN
        run_op("lw_to",  0, 2'd2, 0, 32'h20,       32'h0,        32'h0,        0, -1, 1, 4'b1111, 32'h0,       0, 32'h0,        0, 1, TO + 1);
        run_op("sw_to",  1, 2'd2, 0, 32'h24,       32'h1,        32'h0,       -1, 0, 1, 4'b1111, 32'h1,        0, 32'h0,        0, 1, TO + 1);
`endif

        // Reset while a load sits in WAIT, then a late rvalid arrives.
        @(posedge clk); #1;
        op_we = 1'b0; op_size = 2'd2; op_unsigned = 1'b0; op_addr = 32'h30; op_valid = 1'b1;
        @(posedge clk); #1;
        chk("rw_req", 32'(mem_req), 32'd1);
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        chk("rw_wait_stall", 32'(stall), 32'd1);
        #2 op_valid = 1'b0; rst_n = 1'b0;
        #1 chk_all_zero("rw_rst");
        model_ld = '0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1 mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
        @(posedge clk); #1 mem_rvalid = 1'b0;
        chk_all_zero("rw_late");
        @(posedge clk); #1;
        chk("rw_late_done", 32'(load_done), 32'd0);

        // Recovery after reset.
        run_op("lbu_rc", 0, 2'd0, 1, 32'h0, 32'h0, 32'h000000FF, 0, 0, 1, 4'b1111, 32'h0, 1, 32'h000000FF, 0, 0, 3);

        repeat (3) @(posedge clk);
        #1 chk("sb_empty", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
